// File: rtl/ipsxe_floating_point_horner_sched_v1_0_pkg.sv
// ipsxe_floating_point_horner_sched_v1_0_pkg: shared FSM encodings and latency formula for the Horner scheduler
package ipsxe_floating_point_horner_sched_v1_0_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
  function automatic int latency(input int n_deg, input int mac_latency);
    return 2 + n_deg * (mac_latency + 1);
  endfunction
endpackage

// File: rtl/ipsxe_floating_point_horner_sched_v1_0_if.sv
// ipsxe_floating_point_horner_sched_v1_0_if: request, coefficient, MAC and result bundle of the Horner scheduler
interface ipsxe_floating_point_horner_sched_v1_0_if #(
  parameter int COEF_WIDTH = 24,
  parameter int Z_WIDTH = 10,
  parameter int N_DEG = 4
);
  localparam int AW = $clog2(N_DEG + 1);
  logic i_valid;
  logic o_ready;
  logic [Z_WIDTH-1:0] i_z;
  logic [AW-1:0] o_coef_addr;
  logic [COEF_WIDTH-1:0] i_coef;
  logic [COEF_WIDTH-1:0] o_mac_x;
  logic [Z_WIDTH-1:0] o_mac_y;
  logic [COEF_WIDTH-1:0] o_mac_z;
  logic [COEF_WIDTH-1:0] i_mac_p;
  logic o_valid;
  logic i_ready;
  logic [COEF_WIDTH-1:0] o_result;
  logic o_busy;
  modport slave (
    input i_valid, i_z, i_coef, i_mac_p, i_ready,
    output o_ready, o_coef_addr, o_mac_x, o_mac_y, o_mac_z, o_valid, o_result, o_busy
  );
  modport master (
    output i_valid, i_z, i_coef, i_mac_p, i_ready,
    input o_ready, o_coef_addr, o_mac_x, o_mac_y, o_mac_z, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/ipsxe_floating_point_horner_sched_v1_0.sv
// ipsxe_floating_point_horner_sched_v1_0: Horner-rule polynomial controller time-sharing one external multiply-add unit
module ipsxe_floating_point_horner_sched_v1_0
  import ipsxe_floating_point_horner_sched_v1_0_pkg::*;
#(
  parameter int COEF_WIDTH = 24,
  parameter int Z_WIDTH = 10,
  parameter int N_DEG = 4,
  parameter int MAC_LATENCY = 1
) (
  input logic i_clk,
  input logic i_rst,
  ipsxe_floating_point_horner_sched_v1_0_if.slave bus
);
  localparam int AW = $clog2(N_DEG + 1);
  state_t state, state_n;
  logic [Z_WIDTH-1:0] z_q;
  logic [COEF_WIDTH-1:0] acc, result;
  logic [AW-1:0] addr, k;
  logic [1:0] cnt;
  logic cap;
  assign cap = (state == ISSUE && MAC_LATENCY == 0) || (state == WAIT && cnt == 2'd1);
  assign bus.o_ready = state == IDLE;
  assign bus.o_busy = state != IDLE;
  assign bus.o_valid = state == DONE;
  assign bus.o_coef_addr = addr;
  assign bus.o_mac_x = acc;
  assign bus.o_mac_y = z_q;
  assign bus.o_mac_z = bus.i_coef;
  assign bus.o_result = result;
  // next-state: a step ends at the capture edge, the last step moves on to DONE
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = bus.i_valid ? LOAD : IDLE;
      LOAD: state_n = ISSUE;
      ISSUE, WAIT: state_n = cap ? (k == '0 ? DONE : ISSUE) : WAIT;
      DONE: state_n = bus.i_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // datapath registers; the capture update is last so it wins over the per-state loads
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      z_q <= '0;
      acc <= '0;
      result <= '0;
      addr <= '0;
      k <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (bus.i_valid) begin
          z_q <= bus.i_z;
          addr <= AW'(N_DEG);
        end
        LOAD: begin
          acc <= bus.i_coef;
          addr <= AW'(N_DEG - 1);
          k <= AW'(N_DEG - 1);
        end
        ISSUE: cnt <= 2'(MAC_LATENCY);
        WAIT: cnt <= cnt - 2'd1;
        default: ;
      endcase
      if (cap) begin
        acc <= bus.i_mac_p;
        if (k == '0) result <= bus.i_mac_p;
        else begin
          k <= k - 1'b1;
          addr <= addr - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ipsxe_floating_point_horner_sched_v1_0.sv
// tb_ipsxe_floating_point_horner_sched_v1_0: directed checks of the Horner scheduler against bench MAC models
module tb_ipsxe_floating_point_horner_sched_v1_0;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  ipsxe_floating_point_horner_sched_v1_0_if #(.COEF_WIDTH(24), .Z_WIDTH(10), .N_DEG(2)) bus_a ();
  ipsxe_floating_point_horner_sched_v1_0_if #(.COEF_WIDTH(24), .Z_WIDTH(10), .N_DEG(2)) bus_b ();
  ipsxe_floating_point_horner_sched_v1_0_if #(.COEF_WIDTH(24), .Z_WIDTH(10), .N_DEG(15)) bus_c ();
  ipsxe_floating_point_horner_sched_v1_0 #(.COEF_WIDTH(24), .Z_WIDTH(10), .N_DEG(2), .MAC_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .bus(bus_a));
  ipsxe_floating_point_horner_sched_v1_0 #(.COEF_WIDTH(24), .Z_WIDTH(10), .N_DEG(2), .MAC_LATENCY(0)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .bus(bus_b));
  ipsxe_floating_point_horner_sched_v1_0 #(.COEF_WIDTH(24), .Z_WIDTH(10), .N_DEG(15), .MAC_LATENCY(3)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .bus(bus_c));
  // coefficient tables: c = {3,2,1} for degree 2, c_k = k+1 for degree 15
  assign bus_a.i_coef = 24'd3 - 24'(bus_a.o_coef_addr);
  assign bus_b.i_coef = 24'd3 - 24'(bus_b.o_coef_addr);
  assign bus_c.i_coef = 24'(bus_c.o_coef_addr) + 24'd1;
  // MAC models P = Z + X*Y mod 2^24 with latency 1, 0 and 3
  logic [23:0] p_a, p_c0, p_c1, p_c2;
  always_ff @(posedge clk) p_a <= bus_a.o_mac_z + bus_a.o_mac_x * 24'(bus_a.o_mac_y);
  assign bus_a.i_mac_p = p_a;
  assign bus_b.i_mac_p = bus_b.o_mac_z + bus_b.o_mac_x * 24'(bus_b.o_mac_y);
  always_ff @(posedge clk) begin
    p_c0 <= bus_c.o_mac_z + bus_c.o_mac_x * 24'(bus_c.o_mac_y);
    p_c1 <= p_c0;
    p_c2 <= p_c1;
  end
  assign bus_c.i_mac_p = p_c2;
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bad;
    rst_a = 1; rst_b = 1; rst_c = 1;
    bus_a.i_valid = 0; bus_a.i_z = '0; bus_a.i_ready = 0;
    bus_b.i_valid = 0; bus_b.i_z = '0; bus_b.i_ready = 0;
    bus_c.i_valid = 0; bus_c.i_z = '0; bus_c.i_ready = 0;
    tick; tick;
    check("rst_ready", bus_a.o_ready, 1);
    check("rst_busy", bus_a.o_busy, 0);
    check("rst_valid", bus_a.o_valid, 0);
    check("rst_addr", bus_a.o_coef_addr, 0);
    check("rst_result", bus_a.o_result, 0);
    check("rst_mac_x", bus_a.o_mac_x, 0);
    rst_a = 0; rst_b = 0; rst_c = 0;
    bus_a.i_z = 10'd5; bus_a.i_valid = 1; cyc = 0;
    tick;
    bus_a.i_valid = 0;
    check("a_load_busy", bus_a.o_busy, 1);
    check("a_load_addr", bus_a.o_coef_addr, 2);
    tick;
    check("a_s1_addr", bus_a.o_coef_addr, 1);
    check("a_s1_mac_x", bus_a.o_mac_x, 1);
    check("a_s1_mac_y", bus_a.o_mac_y, 5);
    check("a_s1_mac_z", bus_a.o_mac_z, 2);
    tick;
    bus_a.i_z = 10'd9; bus_a.i_valid = 1;
    tick;
    bus_a.i_valid = 0;
    bad = 0;
    for (int i = 0; i < 20 && !bus_a.o_valid; i++) begin
      if (bus_a.o_ready) bad++;
      tick;
    end
    check("a_ready_low_while_busy", bad, 0);
    check("a_valid_cycle", cyc, 6);
    check("a_result", bus_a.o_result, 38);
    for (int i = 0; i < 5; i++) begin
      check("a_hold_valid", bus_a.o_valid, 1);
      check("a_hold_result", bus_a.o_result, 38);
      tick;
    end
    bus_a.i_ready = 1;
    tick;
    bus_a.i_ready = 0;
    check("a_post_ready", bus_a.o_ready, 1);
    check("a_post_valid", bus_a.o_valid, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.o_valid || bus_a.o_busy) bad++;
      tick;
    end
    check("a_single_result", bad, 0);
    bus_a.i_z = 10'd3; bus_a.i_valid = 1; cyc = 0;
    tick;
    bus_a.i_valid = 0;
    tick; tick;
    rst_a = 1;
    tick;
    rst_a = 0;
    check("a_rst_valid", bus_a.o_valid, 0);
    check("a_rst_ready", bus_a.o_ready, 1);
    check("a_rst_busy", bus_a.o_busy, 0);
    check("a_rst_addr", bus_a.o_coef_addr, 0);
    check("a_rst_result", bus_a.o_result, 0);
    check("a_rst_mac_x", bus_a.o_mac_x, 0);
    check("a_rst_mac_y", bus_a.o_mac_y, 0);
    bus_a.i_z = 10'd2; bus_a.i_valid = 1; cyc = 0;
    tick;
    bus_a.i_valid = 0;
    check("a_rst_reaccept", bus_a.o_busy, 1);
    for (int i = 0; i < 20 && !bus_a.o_valid; i++) tick;
    check("a_z2_valid_cycle", cyc, 6);
    check("a_z2_result", bus_a.o_result, 11);
    bus_a.i_ready = 1;
    tick;
    bus_a.i_ready = 0;
    bus_b.i_z = 10'd0; bus_b.i_valid = 1; cyc = 0;
    tick;
    bus_b.i_valid = 0;
    tick;
    check("b_s1_mac_x", bus_b.o_mac_x, 1);
    tick;
    check("b_s2_mac_x", bus_b.o_mac_x, 2);
    for (int i = 0; i < 20 && !bus_b.o_valid; i++) tick;
    check("b_valid_cycle", cyc, 4);
    check("b_result", bus_b.o_result, 3);
    bus_b.i_ready = 1;
    tick;
    bus_b.i_ready = 0;
    check("b_post_ready", bus_b.o_ready, 1);
    bus_c.i_z = 10'd1; bus_c.i_valid = 1; cyc = 0;
    tick;
    bus_c.i_valid = 0;
    check("c_load_addr", bus_c.o_coef_addr, 15);
    tick;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("c_addr_s%0d_%0d", s, j), bus_c.o_coef_addr, 14 - s);
        if (bus_c.o_valid) bad++;
        tick;
      end
    end
    check("c_valid_cycle62", bus_c.o_valid, 1);
    check("c_cycle", cyc, 62);
    check("c_result", bus_c.o_result, 136);
    bus_c.i_ready = 1;
    tick;
    bus_c.i_ready = 0;
    check("c_post_ready", bus_c.o_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
